// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS unified-memory port arbiter.
// Defines the arbiter state encoding, mux selector values and default widths.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic SEL_IF  = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    localparam int unsigned DEF_N           = 32;
    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_WAIT_CYCLES = 1;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter timing a RAM access; load sets WAIT_CYCLES-1, zero_o flags expiry.
// Decrement saturates at zero; load has priority over decrement.
module arb_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);
    localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port RAM between IF and MEM requesters; each access takes WAIT_CYCLES+2 cycles.
// MEM wins ties unless ARB_ROUND_ROBIN_EN is defined, which alternates grants on simultaneous requests.
module memory_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned N           = DEF_N,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [N-1:0]      if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [N-1:0]      mem_wdata,
    output logic              mem_ready,
    output logic [N-1:0]      mem_rdata,
    output logic              mux_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [N-1:0]      ram_wdata,
    output logic              ram_we,
    input  logic [N-1:0]      ram_rdata,
    output logic              busy
);
    arb_state_e        state_q;
    logic              mux_sel_q;
    logic              ram_we_q;
    logic              acc_we_q;
    logic              if_ready_q;
    logic              mem_ready_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [N-1:0]      ram_wdata_q;
    logic [N-1:0]      if_rdata_q;
    logic [N-1:0]      mem_rdata_q;
    logic              grant_mem;
    logic              any_req;
    logic              cnt_load;
    logic              cnt_zero;

    assign any_req = if_req | mem_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;
    // On a tie the requester that lost last time is served first.
    assign grant_mem = mem_req & (~if_req | (last_grant_q == SEL_IF));
`else
    assign grant_mem = mem_req;
`endif

    assign cnt_load = (state_q == IDLE) & any_req;

    arb_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk_i  (clk),
        .reset_i(reset),
        .load_i (cnt_load),
        .dec_i  (state_q == ACCESS),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mux_sel_q   <= SEL_IF;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            acc_we_q    <= 1'b0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= SEL_IF;
`endif
        end else begin
            ram_we_q    <= 1'b0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q     <= ACCESS;
                        mux_sel_q   <= grant_mem ? SEL_MEM : SEL_IF;
                        ram_addr_q  <= grant_mem ? mem_addr : if_addr;
                        ram_wdata_q <= mem_wdata;
                        ram_we_q    <= grant_mem & mem_we;
                        acc_we_q    <= grant_mem & mem_we;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= grant_mem ? SEL_MEM : SEL_IF;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        state_q <= RESP;
                        if (mux_sel_q == SEL_MEM) begin
                            mem_ready_q <= 1'b1;
                            // A store leaves the load-data register untouched.
                            if (!acc_we_q) begin
                                mem_rdata_q <= ram_rdata;
                            end
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= ram_rdata;
                        end
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign mux_sel   = mux_sel_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign busy      = (state_q != IDLE);

endmodule
